// File: rtl/fifo_ctrl8_if.sv
// fifo_ctrl8_if: write/read handshake and status bundle for the fifo_ctrl8 FIFO.
interface fifo_ctrl8_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 8
) ();
    logic                      wr_enb;
    logic [DATA_W-1:0]         wr_data;
    logic                      rd_enb;
    logic [DATA_W-1:0]         rd_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_almost_full;
    logic                      fifo_almost_empty;
    logic                      fifo_overrun;
    logic                      fifo_underrun;
    logic [$clog2(DEPTH):0]    fifo_count;
    modport master (
        output wr_enb, wr_data, rd_enb,
        input  rd_data, fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty,
               fifo_overrun, fifo_underrun, fifo_count
    );
    modport slave (
        input  wr_enb, wr_data, rd_enb,
        output rd_data, fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty,
               fifo_overrun, fifo_underrun, fifo_count
    );
endinterface

// File: rtl/fifo_ctrl8.sv
// fifo_ctrl8: single-clock FIFO with registered read data, registered status flags
// and one-cycle overrun/underrun pulses.
module fifo_ctrl8 #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 8
) (
    input logic clk,
    input logic rst,
    fifo_ctrl8_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT = (AW+1)'(1);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, count_nxt;
    logic [DATA_W-1:0] rd_data;
    logic full, empty, almost_full, almost_empty, overrun, underrun;
    logic wr_ok, rd_ok;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    always_comb begin
        rd_ok = bus.rd_enb && !empty;
        wr_ok = bus.wr_enb && (!full || rd_ok);
        count_nxt = (wr_ok && !rd_ok) ? count + 1'b1 : (rd_ok && !wr_ok) ? count - 1'b1 : count;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            rd_data <= '0;
            full <= 1'b0;
            empty <= 1'b1;
            almost_full <= 1'b0;
            almost_empty <= 1'b1;
            overrun <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            count <= count_nxt;
            full <= count_nxt == FULL_CNT;
            empty <= count_nxt == '0;
            almost_full <= count_nxt >= FULL_CNT - ONE_CNT;
            almost_empty <= count_nxt <= ONE_CNT;
            overrun <= bus.wr_enb && !wr_ok;
            underrun <= bus.rd_enb && !rd_ok;
        end
    end
    // Storage is left uncleared on reset; the empty flag keeps stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= bus.wr_data;
    end
    assign bus.rd_data = rd_data;
    assign bus.fifo_full = full;
    assign bus.fifo_empty = empty;
    assign bus.fifo_almost_full = almost_full;
    assign bus.fifo_almost_empty = almost_empty;
    assign bus.fifo_overrun = overrun;
    assign bus.fifo_underrun = underrun;
    assign bus.fifo_count = count;
endmodule

// File: tb/tb_fifo_ctrl8.sv
// tb_fifo_ctrl8: directed bench for fifo_ctrl8 with a queue-based reference model
// compared on every falling edge, plus literal expectations per scenario.
module tb_fifo_ctrl8;
    localparam int DATA_W = 8;
    localparam int DEPTH = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    fifo_ctrl8_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
    fifo_ctrl8 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_rd = '0;
    logic m_over = 1'b0;
    logic m_under = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queue semantics taken from the accept rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_rd <= '0;
            m_over <= 1'b0;
            m_under <= 1'b0;
        end else begin
            automatic bit rd_ok = bus.rd_enb && q.size() > 0;
            automatic bit wr_ok = bus.wr_enb && (q.size() < DEPTH || rd_ok);
            if (rd_ok) m_rd <= q.pop_front();
            if (wr_ok) q.push_back(bus.wr_data);
            m_over <= bus.wr_enb && !wr_ok;
            m_under <= bus.rd_enb && !rd_ok;
        end
    end

    always @(negedge clk) begin
        automatic int n = q.size();
        chk("m_count", 32'(bus.fifo_count), 32'(n));
        chk("m_rd_data", 32'(bus.rd_data), 32'(m_rd));
        chk("m_full", 32'(bus.fifo_full), 32'(n == DEPTH));
        chk("m_empty", 32'(bus.fifo_empty), 32'(n == 0));
        chk("m_almost_full", 32'(bus.fifo_almost_full), 32'(n >= DEPTH - 1));
        chk("m_almost_empty", 32'(bus.fifo_almost_empty), 32'(n <= 1));
        chk("m_overrun", 32'(bus.fifo_overrun), 32'(m_over));
        chk("m_underrun", 32'(bus.fifo_underrun), 32'(m_under));
    end

    task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r);
        @(negedge clk);
        bus.wr_enb = w;
        bus.wr_data = d;
        bus.rd_enb = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, 32'(bus.fifo_count), 0);
        chk({tag, "_empty"}, 32'(bus.fifo_empty), 1);
        chk({tag, "_aempty"}, 32'(bus.fifo_almost_empty), 1);
        chk({tag, "_full"}, 32'(bus.fifo_full), 0);
        chk({tag, "_afull"}, 32'(bus.fifo_almost_full), 0);
        chk({tag, "_over"}, 32'(bus.fifo_overrun), 0);
        chk({tag, "_under"}, 32'(bus.fifo_underrun), 0);
        chk({tag, "_rd_data"}, 32'(bus.rd_data), 0);
    endtask

    initial begin
        bus.wr_enb = 1'b0;
        bus.wr_data = '0;
        bus.rd_enb = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        step(1, 8'hA5, 0);
        chk("single_wr_count", 32'(bus.fifo_count), 1);
        step(0, 0, 1);
        chk("single_rd_count", 32'(bus.fifo_count), 0);
        chk("single_rd_data", 32'(bus.rd_data), 32'hA5);

        for (int i = 0; i < 8; i++) begin
            step(1, 8'(8'h10 + i), 0);
            chk("fill_count", 32'(bus.fifo_count), 32'(i + 1));
            chk("fill_afull", 32'(bus.fifo_almost_full), 32'(i >= 6));
            chk("fill_full", 32'(bus.fifo_full), 32'(i == 7));
        end
        step(1, 8'h99, 0);
        chk("overrun_pulse", 32'(bus.fifo_overrun), 1);
        chk("overrun_count", 32'(bus.fifo_count), 8);
        step(0, 0, 0);
        chk("overrun_clear", 32'(bus.fifo_overrun), 0);

        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1);
            chk("drain_data", 32'(bus.rd_data), 32'(8'h10 + i));
        end
        chk("drain_empty", 32'(bus.fifo_empty), 1);
        step(0, 0, 1);
        chk("underrun_pulse", 32'(bus.fifo_underrun), 1);
        chk("underrun_hold", 32'(bus.rd_data), 32'h17);
        step(0, 0, 0);
        chk("underrun_clear", 32'(bus.fifo_underrun), 0);

        for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0);
        step(1, 8'h20, 1);
        chk("simul_rd_data", 32'(bus.rd_data), 32'h10);
        chk("simul_count", 32'(bus.fifo_count), 8);
        chk("simul_overrun", 32'(bus.fifo_overrun), 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1);
        chk("simul_last", 32'(bus.rd_data), 32'h20);

        step(1, 8'h55, 1);
        chk("empty_both_under", 32'(bus.fifo_underrun), 1);
        chk("empty_both_count", 32'(bus.fifo_count), 1);
        chk("empty_both_hold", 32'(bus.rd_data), 32'h20);
        step(0, 0, 1);
        chk("empty_both_read", 32'(bus.rd_data), 32'h55);

        step(1, 8'h01, 0);
        step(1, 8'h02, 0);
        step(1, 8'h03, 0);
        chk("midfill_count", 32'(bus.fifo_count), 3);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        bus.wr_enb = 1'b0;
        bus.rd_enb = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_under", 32'(bus.fifo_underrun), 1);
        chk("post_rst_rd_data", 32'(bus.rd_data), 0);
        step(0, 0, 0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
